// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared encodings and shadow-slot layout for the EX-stage forwarding/hazard controller.
package forward_hazard_ctrl_pkg;

    localparam int REG_W   = 5;
    localparam int CORTO_W = 3;

    localparam logic [CORTO_W-1:0] CORTO_REG   = 3'b000;
    localparam logic [CORTO_W-1:0] CORTO_EXMEM = 3'b001;
    localparam logic [CORTO_W-1:0] CORTO_MEMWB = 3'b010;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             memread;
    } slot_t;

endpackage

// File: rtl/forward_hazard_ctrl_if.sv
// ID-stage request and EX-mux/stall response bundle of the forwarding/hazard controller.
interface forward_hazard_ctrl_if #(
    parameter int BITS_REG           = 5,
    parameter int BITS_CORTOCIRCUITO = 3,
    parameter int BITS_COUNT         = 32
);
    logic                          i_halt;
    logic                          i_flush;
    logic [BITS_REG-1:0]           i_id_rs;
    logic [BITS_REG-1:0]           i_id_rt;
    logic                          i_id_use_rs;
    logic                          i_id_use_rt;
    logic [BITS_REG-1:0]           i_id_dest;
    logic                          i_id_regwrite;
    logic                          i_id_memread;
    logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A;
    logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B;
    logic                          o_stall_pc;
    logic                          o_stall_ifid;
    logic                          o_bubble_idex;
    logic [BITS_COUNT-1:0]         o_stall_count;

    modport master (
        output i_halt, i_flush, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
               i_id_dest, i_id_regwrite, i_id_memread,
        input  o_corto_register_A, o_corto_register_B, o_stall_pc, o_stall_ifid,
               o_bubble_idex, o_stall_count
    );

    modport slave (
        input  i_halt, i_flush, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
               i_id_dest, i_id_regwrite, i_id_memread,
        output o_corto_register_A, o_corto_register_B, o_stall_pc, o_stall_ifid,
               o_bubble_idex, o_stall_count
    );
endinterface

// File: rtl/forward_hazard_ctrl_fwd_select.sv
// Forwarding select for one ALU source against the EX and MEM shadow slots.
module fwd_select
    import forward_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0]   src,
    input  logic               use_src,
    input  logic               ex_valid,
    input  logic [REG_W-1:0]   ex_dest,
    input  logic               mem_valid,
    input  logic [REG_W-1:0]   mem_dest,
    output logic [CORTO_W-1:0] sel
);
    always_comb begin
        sel = CORTO_REG;
        // EX is checked first so the newest producer wins; r0 is never forwarded.
        if (use_src && (src != '0)) begin
            if (ex_valid && (src == ex_dest)) begin
                sel = CORTO_EXMEM;
            end else if (mem_valid && (src == mem_dest)) begin
                sel = CORTO_MEMWB;
            end
        end
    end
endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding/hazard controller: shadow scoreboard, load-use stall, flush/halt priority, stall counter.
module forward_hazard_ctrl
    import forward_hazard_ctrl_pkg::*;
#(
    parameter int BITS_REG           = REG_W,
    parameter int BITS_CORTOCIRCUITO = CORTO_W,
    parameter int BITS_COUNT         = 32
) (
    input logic                  i_clk,
    input logic                  i_reset_n,
    forward_hazard_ctrl_if.slave bus
);
    slot_t                         id_slot;
    slot_t                         ex_q;
    logic                          mem_valid_q;
    logic [BITS_REG-1:0]           mem_dest_q;
    logic [BITS_CORTOCIRCUITO-1:0] sel_a_d, sel_b_d;
    logic [BITS_CORTOCIRCUITO-1:0] sel_a_q, sel_b_q;
    logic [BITS_COUNT-1:0]         count_q;
    logic                          load_use;
    logic                          kill;

    always_comb begin
        id_slot.valid   = bus.i_id_regwrite && (bus.i_id_dest != '0);
        id_slot.dest    = bus.i_id_dest;
        id_slot.memread = bus.i_id_memread;
    end

    assign load_use = ex_q.valid && ex_q.memread &&
                      ((bus.i_id_use_rs && (bus.i_id_rs == ex_q.dest)) ||
                       (bus.i_id_use_rt && (bus.i_id_rt == ex_q.dest)));
    assign kill = bus.i_flush || load_use;

    fwd_select u_fwd_a (
        .src       (bus.i_id_rs),
        .use_src   (bus.i_id_use_rs),
        .ex_valid  (ex_q.valid),
        .ex_dest   (ex_q.dest),
        .mem_valid (mem_valid_q),
        .mem_dest  (mem_dest_q),
        .sel       (sel_a_d)
    );

    fwd_select u_fwd_b (
        .src       (bus.i_id_rt),
        .use_src   (bus.i_id_use_rt),
        .ex_valid  (ex_q.valid),
        .ex_dest   (ex_q.dest),
        .mem_valid (mem_valid_q),
        .mem_dest  (mem_dest_q),
        .sel       (sel_b_d)
    );

    // WB never forwards (regfile writes before it reads), so only EX and MEM are held.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ex_q        <= '0;
            mem_valid_q <= 1'b0;
            mem_dest_q  <= '0;
            sel_a_q     <= CORTO_REG;
            sel_b_q     <= CORTO_REG;
            count_q     <= '0;
        end else if (!bus.i_halt) begin
            ex_q        <= kill ? '0 : id_slot;
            mem_valid_q <= ex_q.valid;
            mem_dest_q  <= ex_q.dest;
            sel_a_q     <= kill ? CORTO_REG : sel_a_d;
            sel_b_q     <= kill ? CORTO_REG : sel_b_d;
            // A flushed consumer is dead, so its would-be stall is not counted.
            if (load_use && !bus.i_flush && (count_q != '1)) begin
                count_q <= count_q + BITS_COUNT'(1);
            end
        end
    end

    assign bus.o_stall_pc         = bus.i_halt || (load_use && !bus.i_flush);
    assign bus.o_stall_ifid       = bus.i_halt || (load_use && !bus.i_flush);
    assign bus.o_bubble_idex      = !bus.i_halt && kill;
    assign bus.o_corto_register_A = sel_a_q;
    assign bus.o_corto_register_B = sel_b_q;
    assign bus.o_stall_count      = count_q;
endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Directed + randomized check of forward_hazard_ctrl against a pipeline-history reference model.
module tb_forward_hazard_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    int   hd[$];
    bit   hl[$];
    int   m_a, m_b, m_cnt;
    logic last_pc, last_ifid, last_bub;

    forward_hazard_ctrl_if #(.BITS_COUNT(CW)) bus ();

    forward_hazard_ctrl #(.BITS_COUNT(CW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        hd = '{-1, -1};
        hl = '{0, 0};
        m_a = 0;
        m_b = 0;
        m_cnt = 0;
    endfunction

    // hd[0] is the instruction now in EX, hd[1] the one in MEM; -1 means no register write.
    function automatic int msel(input int s, input bit u);
        if (!u || s == 0) return 0;
        if (hd[0] == s) return 1;
        if (hd[1] == s) return 2;
        return 0;
    endfunction

    task automatic step(input bit halt, input bit flush, input int rs, input int rt,
                        input bit urs, input bit urt, input int dest, input bit rw, input bit mr);
        bit ld;
        @(negedge clk);
        bus.i_halt        = halt;
        bus.i_flush       = flush;
        bus.i_id_rs       = 5'(rs);
        bus.i_id_rt       = 5'(rt);
        bus.i_id_use_rs   = urs;
        bus.i_id_use_rt   = urt;
        bus.i_id_dest     = 5'(dest);
        bus.i_id_regwrite = rw;
        bus.i_id_memread  = mr;
        #1;
        ld = hl[0] && ((urs && rs == hd[0]) || (urt && rt == hd[0]));
        last_pc   = bus.o_stall_pc;
        last_ifid = bus.o_stall_ifid;
        last_bub  = bus.o_bubble_idex;
        check("stall_pc", 32'(last_pc), 32'(halt || (ld && !flush)));
        check("stall_ifid", 32'(last_ifid), 32'(halt || (ld && !flush)));
        check("bubble_idex", 32'(last_bub), 32'(!halt && (flush || ld)));
        @(posedge clk);
        #1;
        if (!halt) begin
            m_a = (ld || flush) ? 0 : msel(rs, urs);
            m_b = (ld || flush) ? 0 : msel(rt, urt);
            if (ld && !flush && m_cnt < (2**CW - 1)) m_cnt++;
            hd.push_front((ld || flush || !rw || dest == 0) ? -1 : dest);
            hl.push_front(!(ld || flush || !rw || dest == 0) && mr);
            void'(hd.pop_back());
            void'(hl.pop_back());
        end
        check("corto_A", 32'(bus.o_corto_register_A), 32'(m_a));
        check("corto_B", 32'(bus.o_corto_register_B), 32'(m_b));
        check("stall_count", 32'(bus.o_stall_count), 32'(m_cnt));
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        bus.i_halt = 0; bus.i_flush = 0; bus.i_id_rs = '0; bus.i_id_rt = '0;
        bus.i_id_use_rs = 0; bus.i_id_use_rt = 0; bus.i_id_dest = '0;
        bus.i_id_regwrite = 0; bus.i_id_memread = 0;
        #12;
        check("rst_A", 32'(bus.o_corto_register_A), 32'd0);
        check("rst_B", 32'(bus.o_corto_register_B), 32'd0);
        check("rst_count", 32'(bus.o_stall_count), 32'd0);
        check("rst_stall", 32'(bus.o_stall_pc), 32'd0);
        check("rst_bubble", 32'(bus.o_bubble_idex), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // add r3 ; add r4 <- r3, r5
        step(0, 0, 0, 0, 0, 0, 3, 1, 0);
        step(0, 0, 3, 5, 1, 1, 4, 1, 0);
        check("t1_A", 32'(bus.o_corto_register_A), 32'd1);
        check("t1_B", 32'(bus.o_corto_register_B), 32'd0);
        check("t1_nostall", 32'(last_pc), 32'd0);

        // add r3 ; nop ; sub r6 <- r1, r3
        step(0, 0, 0, 0, 0, 0, 3, 1, 0);
        nop();
        step(0, 0, 1, 3, 1, 1, 6, 1, 0);
        check("t2_B", 32'(bus.o_corto_register_B), 32'd2);
        check("t2_A", 32'(bus.o_corto_register_A), 32'd0);
        // producer at both distances: newest wins
        step(0, 0, 0, 0, 0, 0, 3, 1, 0);
        step(0, 0, 0, 0, 0, 0, 3, 1, 0);
        step(0, 0, 3, 3, 1, 1, 6, 1, 0);
        check("t2_newest", 32'(bus.o_corto_register_A), 32'd1);

        // lw r2 ; add r7 <- r2, r2
        step(0, 0, 0, 0, 0, 0, 2, 1, 1);
        step(0, 0, 2, 2, 1, 1, 7, 1, 0);
        check("t3_stall", 32'(last_pc), 32'd1);
        check("t3_bubble", 32'(last_bub), 32'd1);
        step(0, 0, 2, 2, 1, 1, 7, 1, 0);
        check("t3_nostall", 32'(last_pc), 32'd0);
        check("t3_A", 32'(bus.o_corto_register_A), 32'd2);
        check("t3_B", 32'(bus.o_corto_register_B), 32'd2);
        check("t3_count", 32'(bus.o_stall_count), 32'd1);

        // flush on top of load-use
        step(0, 0, 0, 0, 0, 0, 2, 1, 1);
        step(0, 1, 2, 2, 1, 1, 7, 1, 0);
        check("t4_bubble", 32'(last_bub), 32'd1);
        check("t4_nopc", 32'(last_pc), 32'd0);
        check("t4_count", 32'(bus.o_stall_count), 32'd1);
        nop();

        // r0 is never a hazard source
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1, 8, 1, 0);
        check("t5_nostall", 32'(last_pc), 32'd0);
        check("t5_A", 32'(bus.o_corto_register_A), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        nop();
        step(0, 0, 0, 0, 1, 1, 8, 1, 0);
        check("t5_B", 32'(bus.o_corto_register_B), 32'd0);

        // halt across a load-use stall
        step(0, 0, 0, 0, 0, 0, 2, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 2, 9, 1, 0, 7, 1, 0);
            check("t6_halt_pc", 32'(last_pc), 32'd1);
            check("t6_halt_bub", 32'(last_bub), 32'd0);
            check("t6_halt_cnt", 32'(bus.o_stall_count), 32'd1);
        end
        step(0, 0, 2, 9, 1, 0, 7, 1, 0);
        check("t6_stall", 32'(last_bub), 32'd1);
        step(0, 0, 2, 9, 1, 0, 7, 1, 0);
        check("t6_A", 32'(bus.o_corto_register_A), 32'd2);
        check("t6_count", 32'(bus.o_stall_count), 32'd2);

        // reset mid-stall
        step(0, 0, 0, 0, 0, 0, 5, 1, 1);
        step(0, 0, 0, 0, 0, 0, 6, 1, 0);
        step(0, 0, 6, 0, 1, 0, 9, 1, 0);
        @(negedge clk);
        bus.i_id_rs = 5'd9; bus.i_id_use_rs = 1;
        step(0, 0, 0, 0, 0, 0, 5, 1, 1);
        @(negedge clk);
        bus.i_id_rs = 5'd5; bus.i_id_use_rs = 1; bus.i_id_regwrite = 0; bus.i_id_memread = 0;
        #1;
        check("t6_prestall", 32'(bus.o_stall_pc), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_pc", 32'(bus.o_stall_pc), 32'd0);
        check("t6_rst_A", 32'(bus.o_corto_register_A), 32'd0);
        check("t6_rst_count", 32'(bus.o_stall_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic over a small register set to provoke hits and counter saturation
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                 1'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) < 2);
        end
        check("sat_count", 32'(bus.o_stall_count), 32'(m_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
